oc8051_cxfetch: RTL and testbench

Instruction prefetch queue between the combinational code ROM (`cxrom`) and the oc8051 core. Every cycle it drives a fetch address to the ROM and captures the 4-byte word the ROM returns. It buffers the bytes in a small byte FIFO and presents the oldest three bytes, with their PC, to the core's decoder. The core reports how many bytes it consumed and can redirect fetch on jumps and interrupts.

---
 rtl/oc8051_cxfetch.sv | 134 +++++++++++++
 tb/tb_oc8051_cxfetch.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/oc8051_cxfetch.sv
// Instruction prefetch queue between the combinational code ROM and the oc8051 decoder.
// Optional fetch statistics counters are enabled by defining OC8051_CXFETCH_STATS_EN.
module oc8051_cxfetch #(
   parameter int unsigned DEPTH    = 8,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] cxrom_addr,
   input  logic [31:0] cxrom_data_in,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   input  logic [1:0]  consume,
   output logic [23:0] fetch_bytes,
   output logic [3:0]  fetch_avail,
   output logic [15:0] fetch_pc,
   output logic [15:0] stall_cnt,
   output logic [15:0] redirect_cnt
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   logic [15:0]      fa_q, fa_d;
   logic [15:0]      hp_q, hp_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic [23:0]      fb_q, fb_d;
   logic [7:0]       q_q [DEPTH];
   logic [7:0]       q_d [DEPTH];

   logic [1:0]       ce;
   logic [OCC_W-1:0] occ_left;
   logic             fill;

   // Next queue state; fetch_bytes is precomputed from it so the output is a flop.
   always_comb begin
      ce       = (occ_q < OCC_W'(consume)) ? 2'(occ_q) : consume;
      occ_left = occ_q - OCC_W'(ce);
      fill     = !redirect && (occ_left <= OCC_W'(DEPTH - 4));

      fa_d  = fa_q;
      hp_d  = hp_q + 16'(ce);
      rd_d  = rd_q + PTR_W'(ce);
      wr_d  = wr_q;
      occ_d = occ_left;
      q_d   = q_q;
      fb_d  = '0;

      if (redirect) begin
         fa_d  = redirect_pc;
         hp_d  = redirect_pc;
         rd_d  = '0;
         wr_d  = '0;
         occ_d = '0;
      end else if (fill) begin
         for (int k = 0; k < 4; k++) begin
            q_d[wr_q + PTR_W'(k)] = cxrom_data_in[8*k +: 8];
         end
         wr_d  = wr_q + PTR_W'(4);
         fa_d  = fa_q + 16'd4;
         occ_d = occ_left + OCC_W'(4);
      end

      for (int i = 0; i < 3; i++) begin
         if (OCC_W'(i) < occ_d) begin
            fb_d[8*i +: 8] = q_d[rd_d + PTR_W'(i)];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fa_q  <= RESET_PC;
         hp_q  <= RESET_PC;
         rd_q  <= '0;
         wr_q  <= '0;
         occ_q <= '0;
         fb_q  <= '0;
      end else begin
         fa_q  <= fa_d;
         hp_q  <= hp_d;
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         occ_q <= occ_d;
         fb_q  <= fb_d;
      end
   end

   // Queue storage needs no reset: occupancy gates every read.
   always_ff @(posedge clk) begin
      q_q <= q_d;
   end

   assign cxrom_addr  = fa_q;
   assign fetch_pc    = hp_q;
   assign fetch_avail = 4'(occ_q);
   assign fetch_bytes = fb_q;

`ifdef OC8051_CXFETCH_STATS_EN
   logic [15:0] stall_q, stall_d;
   logic [15:0] rdc_q, rdc_d;

   // Saturating event counters.
   always_comb begin
      stall_d = stall_q;
      rdc_d   = rdc_q;
      if ((occ_q == '0) && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
      if (redirect && (rdc_q != 16'hFFFF)) begin
         rdc_d = rdc_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         rdc_q   <= '0;
      end else begin
         stall_q <= stall_d;
         rdc_q   <= rdc_d;
      end
   end

   assign stall_cnt    = stall_q;
   assign redirect_cnt = rdc_q;
`else
   assign stall_cnt    = 16'h0000;
   assign redirect_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_oc8051_cxfetch.sv
// Self-checking bench for oc8051_cxfetch: byte-queue reference model plus directed literal checks.
module tb_oc8051_cxfetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cxrom_addr;
   logic [31:0] cxrom_data_in;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic [1:0]  consume = 2'd0;
   logic [23:0] fetch_bytes;
   logic [3:0]  fetch_avail;
   logic [15:0] fetch_pc;
   logic [15:0] stall_cnt;
   logic [15:0] redirect_cnt;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   oc8051_cxfetch dut (
      .clk          (clk),
      .rst          (rst),
      .cxrom_addr   (cxrom_addr),
      .cxrom_data_in(cxrom_data_in),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .consume      (consume),
      .fetch_bytes  (fetch_bytes),
      .fetch_avail  (fetch_avail),
      .fetch_pc     (fetch_pc),
      .stall_cnt    (stall_cnt),
      .redirect_cnt (redirect_cnt)
   );

   // ROM content: each byte equals the low byte of its address.
   function automatic logic [7:0] rb(input logic [15:0] a);
      return a[7:0];
   endfunction

   assign cxrom_data_in = {rb(cxrom_addr + 16'd3), rb(cxrom_addr + 16'd2),
                           rb(cxrom_addr + 16'd1), rb(cxrom_addr)};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference model: a byte queue with head PC and fill address.
   logic [7:0]  mq[$];
   logic [15:0] m_hp, m_fa, m_stall, m_rc;
   bit          m_valid = 1'b0;

   always @(posedge clk) begin : model
      int n;
      if (rst) begin
         mq.delete();
         m_hp = 16'h0000;
         m_fa = 16'h0000;
         m_stall = 16'h0000;
         m_rc = 16'h0000;
         m_valid = 1'b1;
      end else if (m_valid) begin
         if (mq.size() == 0 && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
         if (redirect && m_rc != 16'hFFFF) m_rc = m_rc + 16'd1;
         if (redirect) begin
            mq.delete();
            m_hp = redirect_pc;
            m_fa = redirect_pc;
         end else begin
            n = (int'(consume) < mq.size()) ? int'(consume) : mq.size();
            for (int j = 0; j < n; j++) void'(mq.pop_front());
            m_hp = m_hp + 16'(n);
            if (mq.size() + 4 <= 8) begin
               for (int k = 0; k < 4; k++) mq.push_back(rb(m_fa + 16'(k)));
               m_fa = m_fa + 16'd4;
            end
         end
      end
   end

   always @(negedge clk) begin : compare
      logic [23:0] eb;
      if (m_valid) begin
         eb = '0;
         for (int i = 0; i < 3; i++) if (i < mq.size()) eb[8*i +: 8] = mq[i];
         chk("m_avail", 32'(fetch_avail), 32'(mq.size()));
         chk("m_pc", 32'(fetch_pc), 32'(m_hp));
         chk("m_addr", 32'(cxrom_addr), 32'(m_fa));
         chk("m_bytes", 32'(fetch_bytes), 32'(eb));
`ifdef OC8051_CXFETCH_STATS_EN
         chk("m_stall", 32'(stall_cnt), 32'(m_stall));
         chk("m_rdcnt", 32'(redirect_cnt), 32'(m_rc));
`else
         chk("m_stall", 32'(stall_cnt), 32'h0);
         chk("m_rdcnt", 32'(redirect_cnt), 32'h0);
`endif
      end
   end

   task automatic cyc(input logic r, input logic rd, input logic [15:0] pc, input logic [1:0] c);
      rst = r;
      redirect = rd;
      redirect_pc = pc;
      consume = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_av[9] = '{4, 7, 6, 5, 8, 7, 6, 5, 8};
      logic [1:0] pat[8] = '{2'd2, 2'd3, 2'd1, 2'd0, 2'd3, 2'd3, 2'd1, 2'd2};

      cyc(1'b1, 1'b0, 16'h0, 2'd0);
      cyc(1'b1, 1'b0, 16'h0, 2'd0);
      chk("rst_addr", 32'(cxrom_addr), 32'h0);
      chk("rst_avail", 32'(fetch_avail), 32'h0);
      chk("rst_bytes", 32'(fetch_bytes), 32'h0);

      for (int i = 0; i < 9; i++) begin
         cyc(1'b0, 1'b0, 16'h0, 2'd1);
         chk("steady_avail", 32'(fetch_avail), 32'(exp_av[i]));
         chk("steady_pc", 32'(fetch_pc), 32'(i));
         if (i == 0) chk("first_bytes", 32'(fetch_bytes), 32'h020100);
      end
      cyc(1'b0, 1'b0, 16'h0, 2'd1);
      chk("pre_redir_avail", 32'(fetch_avail), 32'd7);

      cyc(1'b0, 1'b1, 16'h1234, 2'd3);
      chk("redir_avail", 32'(fetch_avail), 32'd0);
      chk("redir_pc", 32'(fetch_pc), 32'h1234);
      chk("redir_addr", 32'(cxrom_addr), 32'h1234);
      cyc(1'b0, 1'b0, 16'h0, 2'd0);
      chk("redir_avail2", 32'(fetch_avail), 32'd4);
      chk("redir_bytes", 32'(fetch_bytes), 32'h363534);

      cyc(1'b0, 1'b1, 16'hFFFC, 2'd0);
      chk("wrap_addr0", 32'(cxrom_addr), 32'hFFFC);
      cyc(1'b0, 1'b0, 16'h0, 2'd0);
      chk("wrap_addr1", 32'(cxrom_addr), 32'h0000);
      chk("wrap_avail1", 32'(fetch_avail), 32'd4);
      cyc(1'b0, 1'b0, 16'h0, 2'd0);
      chk("wrap_addr2", 32'(cxrom_addr), 32'h0004);
      chk("wrap_avail2", 32'(fetch_avail), 32'd8);
      cyc(1'b0, 1'b0, 16'h0, 2'd0);
      chk("full_addr", 32'(cxrom_addr), 32'h0004);
      chk("full_avail", 32'(fetch_avail), 32'd8);
      chk("full_bytes", 32'(fetch_bytes), 32'hFEFDFC);
      chk("full_pc", 32'(fetch_pc), 32'hFFFC);
      cyc(1'b0, 1'b0, 16'h0, 2'd3);
      chk("hpwrap_pc1", 32'(fetch_pc), 32'hFFFF);
      chk("hpwrap_avail1", 32'(fetch_avail), 32'd5);
      cyc(1'b0, 1'b0, 16'h0, 2'd3);
      chk("hpwrap_pc2", 32'(fetch_pc), 32'h0002);
      chk("hpwrap_avail2", 32'(fetch_avail), 32'd6);

      cyc(1'b0, 1'b1, 16'h0100, 2'd0);
      cyc(1'b0, 1'b0, 16'h0, 2'd3);
      chk("over_avail", 32'(fetch_avail), 32'd4);
      chk("over_pc", 32'(fetch_pc), 32'h0100);
      chk("over_bytes", 32'(fetch_bytes), 32'h020100);

      // Reset mid-operation with redirect and consume asserted.
      cyc(1'b1, 1'b1, 16'h5555, 2'd3);
      chk("midrst_avail", 32'(fetch_avail), 32'd0);
      chk("midrst_pc", 32'(fetch_pc), 32'h0);
      chk("midrst_addr", 32'(cxrom_addr), 32'h0);
      chk("midrst_bytes", 32'(fetch_bytes), 32'h0);
      chk("midrst_stall", 32'(stall_cnt), 32'h0);
      chk("midrst_rdcnt", 32'(redirect_cnt), 32'h0);

      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 16'h0300, 2'd0);
      cyc(1'b0, 1'b0, 16'h0, 2'd0);
`ifdef OC8051_CXFETCH_STATS_EN
      chk("stats_rdcnt", 32'(redirect_cnt), 32'd3);
      chk("stats_stall", 32'(stall_cnt), 32'd4);
`else
      chk("stats_rdcnt", 32'(redirect_cnt), 32'd0);
      chk("stats_stall", 32'(stall_cnt), 32'd0);
`endif
      chk("stats_avail", 32'(fetch_avail), 32'd4);
      chk("stats_bytes", 32'(fetch_bytes), 32'h020100);

      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 16'h0, pat[i]);
      end
      cyc(1'b0, 1'b0, 16'h0, 2'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
